// File: rtl/config_word_loader.sv
// rtl/config_word_loader.sv - configuration word loader with sequential and addressed load sessions
module config_word_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 39,
    parameter int ADDR_W    = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_start,
    input  logic                          io_mode,
    input  logic                          io_finish,
    input  logic [WORD_W-1:0]             io_d_in,
    input  logic                          io_d_valid,
    output logic                          io_d_ready,
    input  logic [ADDR_W-1:0]             io_addr,
    input  logic [ADDR_W-1:0]             io_rd_addr,
    output logic [WORD_W-1:0]             io_rd_data,
    output logic [WORD_W*NUM_WORDS-1:0]   io_configs_out,
    output logic [ADDR_W:0]               io_count,
    output logic                          io_busy,
    output logic                          io_done,
    output logic                          io_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               mode;
    logic [CNT_W-1:0]   count;
    logic               err;
    logic [WORD_W-1:0]  cfg [NUM_WORDS];
    logic [WORD_W-1:0]  rd_data;
    logic [WORD_W-1:0]  rd_word;

    logic               xfer;
    logic               session_clear;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_idx;
    logic               err_set;
    logic               cnt_inc;

    assign xfer = io_d_valid && (state == LOAD);

    always_comb begin
        state_next    = state;
        session_clear = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = '0;
        err_set       = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (io_start) begin
                    state_next    = LOAD;
                    session_clear = 1'b1;
                end
            end
            LOAD: begin
                if (!mode) begin
                    // Sequential sessions end on the last word; io_finish has no effect.
                    if (xfer) begin
                        wr_en   = 1'b1;
                        wr_idx  = count[ADDR_W-1:0];
                        cnt_inc = 1'b1;
                        if (count == CNT_LAST)
                            state_next = DONE;
                    end
                end else begin
                    if (xfer) begin
                        if ({1'b0, io_addr} < CNT_FULL) begin
                            wr_en  = 1'b1;
                            wr_idx = io_addr;
                        end else begin
                            err_set = 1'b1;
                        end
                        cnt_inc = (count != CNT_FULL);
                    end
                    if (io_finish)
                        state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range readback addresses fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (io_rd_addr == ADDR_W'(k))
                rd_word = cfg[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode    <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
            rd_data <= '0;
            for (int k = 0; k < NUM_WORDS; k++)
                cfg[k] <= '0;
        end else begin
            state   <= state_next;
            rd_data <= rd_word;
            if (session_clear) begin
                mode  <= io_mode;
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (cnt_inc)
                    count <= count + CNT_W'(1);
                if (err_set)
                    err <= 1'b1;
            end
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wr_en && (wr_idx == ADDR_W'(k)))
                    cfg[k] <= io_d_in;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_WORDS; g++) begin : g_cfg_out
            assign io_configs_out[g*WORD_W +: WORD_W] = cfg[g];
        end
    endgenerate

    assign io_d_ready = (state == LOAD);
    assign io_busy    = (state == LOAD);
    assign io_done    = (state == DONE);
    assign io_err     = err;
    assign io_count   = count;
    assign io_rd_data = rd_data;

endmodule

// File: tb/tb_config_word_loader.sv
// tb/tb_config_word_loader.sv - scoreboard bench for config_word_loader
module tb_config_word_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 39;
    localparam int ADDR_W    = 6;
    localparam int VEC_W     = WORD_W * NUM_WORDS;

    logic                clk = 1'b0;
    logic                reset;
    logic                io_start;
    logic                io_mode;
    logic                io_finish;
    logic [WORD_W-1:0]   io_d_in;
    logic                io_d_valid;
    logic                io_d_ready;
    logic [ADDR_W-1:0]   io_addr;
    logic [ADDR_W-1:0]   io_rd_addr;
    logic [WORD_W-1:0]   io_rd_data;
    logic [VEC_W-1:0]    io_configs_out;
    logic [ADDR_W:0]     io_count;
    logic                io_busy;
    logic                io_done;
    logic                io_err;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] mdl [NUM_WORDS];
    logic [WORD_W-1:0] rd_q [$];
    logic [WORD_W-1:0] rd_exp;

    config_word_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .io_start(io_start), .io_mode(io_mode),
        .io_finish(io_finish), .io_d_in(io_d_in), .io_d_valid(io_d_valid),
        .io_d_ready(io_d_ready), .io_addr(io_addr), .io_rd_addr(io_rd_addr),
        .io_rd_data(io_rd_data), .io_configs_out(io_configs_out), .io_count(io_count),
        .io_busy(io_busy), .io_done(io_done), .io_err(io_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] pack_mdl();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < NUM_WORDS; k++)
            v[k*WORD_W +: WORD_W] = mdl[k];
        return v;
    endfunction

    task automatic start_session(input logic mode);
        io_mode  = mode;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; io_start = 0; io_mode = 0; io_finish = 0;
        io_d_in = '0; io_d_valid = 0; io_addr = '0; io_rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) mdl[k] = '0;
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL reset_cfg actual=%h required=0", io_configs_out); end
        checks++; if ({io_busy, io_done, io_d_ready, io_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags actual=%b required=0000", {io_busy, io_done, io_d_ready, io_err}); end
        checks++; if (io_count !== 7'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", io_count); end
        checks++; if (io_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd actual=%h required=0", io_rd_data); end
    endtask

    task automatic test_sequential();
        start_session(1'b0);
        checks++; if ({io_busy, io_d_ready, io_done} !== 3'b110) begin errors++; $display("FAIL seq_start actual=%b required=110", {io_busy, io_d_ready, io_done}); end
        io_d_valid = 1'b1;
        for (int k = 0; k < NUM_WORDS; k++) begin
            io_d_in = WORD_W'(k + 1);
            mdl[k]  = WORD_W'(k + 1);
            if (k == NUM_WORDS - 1) begin
                checks++; if (io_done !== 1'b0) begin errors++; $display("FAIL seq_early_done actual=%b required=0", io_done); end
            end
            tick();
        end
        io_d_valid = 1'b0;
        checks++; if ({io_done, io_busy} !== 2'b10) begin errors++; $display("FAIL seq_done actual=%b required=10", {io_done, io_busy}); end
        checks++; if (io_count !== 7'd39) begin errors++; $display("FAIL seq_count actual=%0d required=39", io_count); end
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL seq_cfg actual=%h required=%h", io_configs_out, pack_mdl()); end
        for (int i = 0; i < 3; i++) begin
            io_rd_addr = (i == 0) ? 6'd0 : (i == 1) ? 6'd17 : 6'd38;
            rd_q.push_back(mdl[io_rd_addr]);
            tick();
            rd_exp = rd_q.pop_front();
            checks++; if (io_rd_data !== rd_exp) begin errors++; $display("FAIL seq_rd[%0d] actual=%h required=%h", io_rd_addr, io_rd_data, rd_exp); end
        end
        checks++; if (io_done !== 1'b1) begin errors++; $display("FAIL seq_done_hold actual=%b required=1", io_done); end
    endtask

    task automatic test_addressed();
        start_session(1'b1);
        checks++; if ({io_busy, io_done, io_count} !== {2'b10, 7'd0}) begin errors++; $display("FAIL addr_start actual=%b/%0d required=10/0", {io_busy, io_done}, io_count); end
        io_d_valid = 1'b1; io_addr = 6'd5; io_d_in = 32'hA5A5A5A5; mdl[5] = 32'hA5A5A5A5;
        tick();
        io_addr = 6'd38; io_d_in = 32'h1; mdl[38] = 32'h1;
        tick();
        io_d_valid = 1'b0; io_finish = 1'b1;
        tick();
        io_finish = 1'b0;
        checks++; if ({io_done, io_busy, io_err} !== 3'b100) begin errors++; $display("FAIL addr_done actual=%b required=100", {io_done, io_busy, io_err}); end
        checks++; if (io_count !== 7'd2) begin errors++; $display("FAIL addr_count actual=%0d required=2", io_count); end
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL addr_cfg actual=%h required=%h", io_configs_out, pack_mdl()); end
    endtask

    task automatic test_addr_err();
        start_session(1'b1);
        io_d_valid = 1'b1; io_addr = 6'd45; io_d_in = 32'hDEADBEEF;
        tick();
        io_d_valid = 1'b0;
        checks++; if (io_err !== 1'b1) begin errors++; $display("FAIL err_set actual=%b required=1", io_err); end
        checks++; if (io_count !== 7'd1) begin errors++; $display("FAIL err_count actual=%0d required=1", io_count); end
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL err_cfg actual=%h required=%h", io_configs_out, pack_mdl()); end
        io_finish = 1'b1; tick(); io_finish = 1'b0;
        checks++; if ({io_err, io_done} !== 2'b11) begin errors++; $display("FAIL err_sticky actual=%b required=11", {io_err, io_done}); end
        start_session(1'b1);
        checks++; if ({io_err, io_count} !== {1'b0, 7'd0}) begin errors++; $display("FAIL err_clear actual=%b/%0d required=0/0", io_err, io_count); end
        io_finish = 1'b1; tick(); io_finish = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_session(1'b0);
        io_d_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            io_d_in = WORD_W'(100 + k);
            tick();
        end
        checks++; if (io_count !== 7'd10) begin errors++; $display("FAIL mid_count actual=%0d required=10", io_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0; io_d_valid = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) mdl[k] = '0;
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL mid_cfg actual=%h required=0", io_configs_out); end
        checks++; if ({io_busy, io_done, io_d_ready, io_count} !== {3'b000, 7'd0}) begin errors++; $display("FAIL mid_state actual=%b/%0d required=000/0", {io_busy, io_done, io_d_ready}, io_count); end
    endtask

    task automatic test_readback();
        start_session(1'b1);
        io_d_valid = 1'b1; io_addr = 6'd5; io_d_in = 32'h11111111; mdl[5] = 32'h11111111;
        tick();
        io_d_in = 32'h22222222; io_rd_addr = 6'd5;
        rd_q.push_back(mdl[5]);
        tick();
        mdl[5] = 32'h22222222;
        io_d_valid = 1'b0;
        rd_exp = rd_q.pop_front();
        checks++; if (io_rd_data !== rd_exp) begin errors++; $display("FAIL rd_old actual=%h required=%h", io_rd_data, rd_exp); end
        rd_q.push_back(mdl[5]);
        tick();
        rd_exp = rd_q.pop_front();
        checks++; if (io_rd_data !== rd_exp) begin errors++; $display("FAIL rd_new actual=%h required=%h", io_rd_data, rd_exp); end
        io_rd_addr = 6'd50;
        rd_q.push_back(32'd0);
        tick();
        rd_exp = rd_q.pop_front();
        checks++; if (io_rd_data !== rd_exp) begin errors++; $display("FAIL rd_oor actual=%h required=%h", io_rd_data, rd_exp); end
        io_finish = 1'b1; tick(); io_finish = 1'b0;
    endtask

    task automatic test_start_mid_load();
        start_session(1'b1);
        io_start = 1'b1; io_mode = 1'b0;
        io_d_valid = 1'b1; io_addr = 6'd7; io_d_in = 32'h77; mdl[7] = 32'h77;
        tick();
        io_start = 1'b0;
        checks++; if ({io_busy, io_count} !== {1'b1, 7'd1}) begin errors++; $display("FAIL mid_start actual=%b/%0d required=1/1", io_busy, io_count); end
        io_addr = 6'd9; io_d_in = 32'h99; mdl[9] = 32'h99; io_finish = 1'b1;
        tick();
        io_d_valid = 1'b0; io_finish = 1'b0;
        checks++; if ({io_done, io_busy, io_count} !== {2'b10, 7'd2}) begin errors++; $display("FAIL fin_xfer actual=%b/%0d required=10/2", {io_done, io_busy}, io_count); end
        checks++; if (io_configs_out !== pack_mdl()) begin errors++; $display("FAIL fin_cfg actual=%h required=%h", io_configs_out, pack_mdl()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_addressed();
        test_addr_err();
        test_reset_mid();
        test_readback();
        test_start_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
